calc_input_ctrl: RTL and testbench

Front-end controller for the calculator board: it is the input-side counterpart of the display decoders. It synchronizes and debounces the raw push-buttons and switches, and walks the user through a power-on/operand-A/operand-B/operation sequence. It presents registered operands, the operation code, a one-cycle `go` strobe and the display enable to the calculator core. It replaces direct wiring of switches and buttons into the core.

---
 rtl/calc_pkg.sv | 29 ++
 rtl/key_debounce.sv | 44 ++++
 rtl/calc_input_ctrl.sv | 111 +++++++++++
 tb/tb_calc_input_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator board: operand width, operation codes
// and the front-end stage codes shown on the status display.
package calc_pkg;

    localparam int unsigned CALC_W = 7;

    typedef enum logic [1:0] {
        OP_SOMA  = 2'b00,
        OP_SUB   = 2'b01,
        OP_MULTI = 2'b10
    } op_t;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_ENT_A  = 3'd1,
        ST_ENT_B  = 3'd2,
        ST_SEL_OP = 3'd3,
        ST_SHOW   = 3'd4
    } stage_t;

    function automatic op_t op_next(input op_t o);
        case (o)
            OP_SOMA: return OP_SUB;
            OP_SUB:  return OP_MULTI;
            default: return OP_SOMA;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchronizer, consecutive-sample debounce and a
// single-cycle pulse on each debounced press (stable 1->0).
module key_debounce #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned    CW   = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);

    logic          s1, s2;
    logic          stable, stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            s1       <= key_n;
            s2       <= s1;
            stable_d <= stable;
            press    <= stable_d & ~stable;
            // stable flips on the DB_CYCLES-th consecutive disagreeing sample
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/calc_input_ctrl.sv
// Calculator front end: debounced keys drive the OFF/A/B/op/show sequence
// and the registered operand, op, go and enable outputs to the core.
module calc_input_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned W         = CALC_W,
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    input  logic         key_pwr_n,
    input  logic         key_next_n,
    input  logic         key_op_n,
    input  logic         key_back_n,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic [1:0]   op,
    output logic         go,
    output logic         en,
    output logic [2:0]   stage
);

    logic [W-1:0] sw_s1, sw_s2;
    logic         ev_pwr, ev_next, ev_op, ev_back;

    stage_t       state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    op_t          op_q, op_d;
    logic         go_q, go_d;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_pwr  (.clk(clk), .rst_n(rst_n), .key_n(key_pwr_n),  .press(ev_pwr));
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_next (.clk(clk), .rst_n(rst_n), .key_n(key_next_n), .press(ev_next));
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_op   (.clk(clk), .rst_n(rst_n), .key_n(key_op_n),   .press(ev_op));
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_back (.clk(clk), .rst_n(rst_n), .key_n(key_back_n), .press(ev_back));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            state_q <= ST_OFF;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_SOMA;
            go_q    <= 1'b0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            go_q    <= go_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;

        case (state_q)
            ST_ENT_A: a_d = sw_s2;
            ST_ENT_B: b_d = sw_s2;
            default:  ;
        endcase

        // one event honoured per cycle: pwr > back > next > op
        if (ev_pwr) begin
            state_d = (state_q == ST_OFF) ? ST_ENT_A : ST_OFF;
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_SOMA;
        end else if (state_q != ST_OFF) begin
            if (ev_back) begin
                case (state_q)
                    ST_ENT_B:  state_d = ST_ENT_A;
                    ST_SEL_OP: state_d = ST_ENT_B;
                    ST_SHOW:   state_d = ST_SEL_OP;
                    default:   ;
                endcase
            end else if (ev_next) begin
                case (state_q)
                    ST_ENT_A:  state_d = ST_ENT_B;
                    ST_ENT_B:  state_d = ST_SEL_OP;
                    ST_SEL_OP: state_d = ST_SHOW;
                    ST_SHOW: begin
                        state_d = ST_ENT_A;
                        a_d     = '0;
                        b_d     = '0;
                        op_d    = OP_SOMA;
                    end
                    default:   ;
                endcase
            end else if (ev_op && state_q == ST_SEL_OP) begin
                op_d = op_next(op_q);
            end
        end

        go_d = (state_d == ST_SHOW) && (state_q != ST_SHOW);
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign op    = op_q;
    assign go    = go_q;
    assign en    = (state_q != ST_OFF);
    assign stage = state_q;

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Scoreboard bench for calc_input_ctrl with a short debounce window.
module tb_calc_input_ctrl;

    localparam int W  = 7;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] sw = '0;
    logic         key_pwr_n = 1'b1, key_next_n = 1'b1, key_op_n = 1'b1, key_back_n = 1'b1;
    logic [W-1:0] a_out, b_out;
    logic [1:0]   op;
    logic         go, en;
    logic [2:0]   stage;

    calc_input_ctrl #(.W(W), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .key_pwr_n(key_pwr_n), .key_next_n(key_next_n),
        .key_op_n(key_op_n), .key_back_n(key_back_n),
        .a_out(a_out), .b_out(b_out), .op(op), .go(go), .en(en), .stage(stage)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int en; int a; int b; int op; int go;
    } rec_t;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;

    // behavioural model: stage number, operands, op index, current switch value
    int m_state = 0, m_a = 0, m_b = 0, m_op = 0, sw_val = 0;

    function automatic rec_t mk_rec(input int g);
        rec_t r;
        r.st = m_state; r.en = (m_state != 0) ? 1 : 0;
        r.a = m_a; r.b = m_b; r.op = m_op; r.go = g;
        return r;
    endfunction

    task automatic model_clear();
        m_a = 0; m_b = 0; m_op = 0;
    endtask

    task automatic model_event(input logic [3:0] m);   // {pwr, back, next, op}
        int old_st, old_op;
        old_st = m_state;
        old_op = m_op;
        if (m_state == 1) m_a = sw_val;
        if (m_state == 2) m_b = sw_val;
        if (m[3]) begin
            m_state = (m_state == 0) ? 1 : 0;
            model_clear();
        end else if (m_state != 0) begin
            if (m[2]) begin
                if (m_state >= 2) m_state = m_state - 1;
            end else if (m[1]) begin
                if (m_state == 4) begin
                    m_state = 1;
                    model_clear();
                end else begin
                    m_state = m_state + 1;
                end
            end else if (m[0] && m_state == 3) begin
                m_op = (m_op + 1) % 3;
            end
        end
        if (m_state == 4 && old_st != 4) begin
            exp_q.push_back(mk_rec(1));
            exp_q.push_back(mk_rec(0));
        end else if (m_state != old_st || m_op != old_op) begin
            exp_q.push_back(mk_rec(0));
        end
    endtask

    task automatic set_keys(input logic [3:0] m);
        key_pwr_n  = ~m[3];
        key_back_n = ~m[2];
        key_next_n = ~m[1];
        key_op_n   = ~m[0];
    endtask

    task automatic set_sw(input int v);
        sw_val = v;
        sw     = W'(v);
    endtask

    // hold >= DB is a real press; shorter is a glitch the model ignores
    task automatic press(input logic [3:0] m, input int hold);
        @(negedge clk);
        if (hold >= DB) model_event(m);
        set_keys(m);
        repeat (hold) @(negedge clk);
        set_keys(4'b0000);
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // monitor: every change of stage/go/op must match the next queued record
    initial begin : monitor
        int pst, pgo, pop;
        rec_t r;
        pst = 0; pgo = 0; pop = 0;
        forever begin
            @(negedge clk);
            if (mon_on && (int'(stage) != pst || int'(go) != pgo || int'(op) != pop)) begin
                pst = int'(stage); pgo = int'(go); pop = int'(op);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got stage=%0d go=%0d op=%0d, expected no change",
                             pst, pgo, pop);
                end else begin
                    r = exp_q.pop_front();
                    if (pst != r.st || int'(en) != r.en || int'(a_out) != r.a ||
                        int'(b_out) != r.b || pop != r.op || pgo != r.go) begin
                        errors++;
                        $display("FAIL record: got st=%0d en=%0d a=%0d b=%0d op=%0d go=%0d, expected st=%0d en=%0d a=%0d b=%0d op=%0d go=%0d",
                                 pst, en, a_out, b_out, pop, pgo, r.st, r.en, r.a, r.b, r.op, r.go);
                    end
                end
            end
        end
    end

    initial begin : stim
        int p_at, s_at, gmax;
        logic [3:0] km;

        // reset and idle
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1'b1;
        gmax = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (go) gmax = 1;
        end
        check("reset_stage", int'(stage), 0);
        check("reset_en", int'(en), 0);
        check("reset_outs", int'(a_out) + int'(b_out) + int'(op), 0);
        check("reset_go_never", gmax, 0);

        // directed sequence
        press(4'b1000, DB + 2);
        set_sw(45);
        press(4'b0010, 3);                     // glitch, no transition
        check("glitch_stage", int'(stage), 1);

        // held next: pulse after DB+2 edges, state one edge later, once only
        @(negedge clk);
        model_event(4'b0010);
        key_next_n = 1'b0;
        p_at = -1; s_at = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (dut.u_next.press && p_at < 0) p_at = i;
            if (stage != 3'd1 && s_at < 0) s_at = i;
        end
        @(negedge clk);
        key_next_n = 1'b1;
        repeat (DB + 4) @(negedge clk);
        check("latency_press", p_at, DB + 2);
        check("latency_stage", s_at, DB + 3);

        set_sw(100);
        press(4'b0010, DB + 2);
        press(4'b0001, DB + 2);
        press(4'b0001, DB + 2);
        press(4'b0010, DB + 2);
        check("show_a", int'(a_out), 45);
        check("show_b", int'(b_out), 100);
        check("show_op", int'(op), 2);
        check("show_stage", int'(stage), 4);

        // back out of SHOW and return; op wraps past MULTI
        press(4'b0100, DB + 2);
        press(4'b0010, DB + 2);
        press(4'b0100, DB + 2);
        press(4'b0001, DB + 2);
        check("op_wrap", int'(op), 0);
        press(4'b0001, DB + 2);
        press(4'b0001, DB + 2);
        check("op_after3", int'(op), 2);

        // simultaneous pwr+next in ENT_B
        press(4'b0010, DB + 2);
        press(4'b0010, DB + 2);
        set_sw(77);
        press(4'b0010, DB + 2);
        press(4'b1010, DB + 2);
        check("pwr_next_en", int'(en), 0);
        check("pwr_next_ops", int'(a_out) + int'(b_out), 0);

        // reset mid-debounce in SEL_OP
        press(4'b1000, DB + 2);
        set_sw(9);
        press(4'b0010, DB + 2);
        press(4'b0010, DB + 2);
        press(4'b0001, DB + 2);
        @(negedge clk);
        key_pwr_n = 1'b0;
        repeat (3) @(negedge clk);
        m_state = 0;
        model_clear();
        exp_q.push_back(mk_rec(0));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_stage", int'(stage), 0);
        check("async_rst_outs", int'(en) + int'(a_out) + int'(b_out) + int'(op) + int'(go), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DB - 1) @(negedge clk);
        key_pwr_n = 1'b1;
        repeat (DB + 4) @(negedge clk);
        press(4'b1000, DB - 1);
        check("post_rst_short", int'(stage), 0);
        press(4'b1000, DB);
        check("post_rst_full", int'(stage), 1);

        // randomized phase
        for (int it = 0; it < 80; it++) begin
            set_sw(int'($urandom_range(0, 127)));
            case ($urandom_range(0, 11))
                0:        km = 4'b1000;
                1, 2:     km = 4'b0100;
                3, 4, 5, 6: km = 4'b0010;
                7, 8, 9:  km = 4'b0001;
                10:       km = 4'b0011;
                default:  km = 4'b0000;
            endcase
            if (m_state == 0) km = 4'b1000;
            if (km == 4'b0000)
                press(4'b0001 << $urandom_range(0, 3), int'($urandom_range(1, DB - 1)));
            else
                press(km, int'($urandom_range(DB, DB + 3)));
        end

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
